// File: rtl/lbc_lbus_target.sv
// LBC local-bus target: claims decoded address phases, paces data phases with
// TRDY/ABORT and forwards every beat to a request/acknowledge backend port.
//
// state    | meaning
// IDLE     | waiting for an address phase (FRAME & IRDY)
// IGNORE   | address missed; wait for the foreign transfer to end
// W_DATA   | write claimed; waiting for master write data (IRDY)
// W_BACK   | write request to backend, waiting for LT_ACK
// R_FETCH  | read request to backend, waiting for LT_ACK
// R_DATA   | read data on bus, waiting for master IRDY
// DONE     | one-cycle write completion (TRDY, ABORT = backend error)
// ABORT    | one-cycle target abort (backend error or timeout)
module lbc_lbus_target #(
    parameter int                ADDR_W  = 30,
    parameter int                DATA_W  = 32,
    parameter logic [ADDR_W-1:0] BASE    = '0,
    parameter logic [ADDR_W-1:0] MASK    = ADDR_W'(30'h3FFF0000),
    parameter int                LINE_W  = 2,
    parameter int                TIMEOUT = 15
) (
    input  logic              BUSCLK,
    input  logic              RESET_LR,
    input  logic              LBUS_FRAME,
    input  logic              LBUS_IRDY,
    input  logic              LBUS_TRDY_IN,
    input  logic              LBUS_WR,
    input  logic [ADDR_W-1:0] LBUS_ADDR,
    input  logic [DATA_W-1:0] LBUS_WDATA,
    output logic              LBUS_TRDY,
    output logic              LBUS_SEL,
    output logic              LBUS_ABORT,
    output logic [DATA_W-1:0] LBUS_RDATA,
    output logic              LBUS_DOE,
    output logic              LT_REQ,
    output logic              LT_WE,
    output logic [ADDR_W-1:0] LT_ADDR,
    output logic [DATA_W-1:0] LT_WDATA,
    input  logic              LT_ACK,
    input  logic              LT_ERR,
    input  logic [DATA_W-1:0] LT_RDATA
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_IGNORE,
        S_W_DATA,
        S_W_BACK,
        S_R_FETCH,
        S_R_DATA,
        S_DONE,
        S_ABORT
    } state_t;

    // Terminal count is one below TIMEOUT: the counter value seen in the
    // TIMEOUT-th waiting cycle, so LT_ACK in that same cycle still wins.
    localparam logic [3:0] TMO_LAST = 4'(TIMEOUT - 1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic [3:0]          r_tmo;
    logic                r_sel;
    logic                r_trdy;
    logic                r_abort;
    logic                r_doe;
    logic                r_req;
    logic                r_we;

    logic                w_hit;
    logic                w_tmo_tc;
    logic [ADDR_W-1:0]   w_addr_next;

    assign w_hit       = ((LBUS_ADDR & MASK) == BASE);
    assign w_tmo_tc    = (r_tmo == TMO_LAST);
    assign w_addr_next = {r_addr[ADDR_W-1:LINE_W], r_addr[LINE_W-1:0] + LINE_W'(1)};

    always_ff @(posedge BUSCLK) begin
        if (RESET_LR) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_tmo   <= '0;
            r_sel   <= 1'b0;
            r_trdy  <= 1'b0;
            r_abort <= 1'b0;
            r_doe   <= 1'b0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (LBUS_FRAME && LBUS_IRDY) begin
                        if (w_hit) begin
                            r_addr <= LBUS_ADDR;
                            r_sel  <= 1'b1;
                            if (LBUS_WR) begin
                                r_state <= S_W_DATA;
                            end else begin
                                r_req   <= 1'b1;
                                r_we    <= 1'b0;
                                r_tmo   <= '0;
                                r_state <= S_R_FETCH;
                            end
                        end else begin
                            r_state <= S_IGNORE;
                        end
                    end
                end
                S_IGNORE: begin
                    if (LBUS_TRDY_IN && LBUS_IRDY && !LBUS_FRAME) begin
                        r_state <= S_IDLE;
                    end
                end
                S_W_DATA: begin
                    if (LBUS_IRDY) begin
                        r_wdata <= LBUS_WDATA;
                        r_req   <= 1'b1;
                        r_we    <= 1'b1;
                        r_tmo   <= '0;
                        r_state <= S_W_BACK;
                    end
                end
                S_W_BACK: begin
                    if (LT_ACK) begin
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
                        r_trdy  <= 1'b1;
                        r_abort <= LT_ERR;
                        r_state <= S_DONE;
                    end else if (w_tmo_tc) begin
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
                        r_trdy  <= 1'b1;
                        r_abort <= 1'b1;
                        r_state <= S_ABORT;
                    end else begin
                        r_tmo <= r_tmo + 4'd1;
                    end
                end
                S_R_FETCH: begin
                    if (LT_ACK) begin
                        r_req  <= 1'b0;
                        r_trdy <= 1'b1;
                        if (LT_ERR) begin
                            r_abort <= 1'b1;
                            r_state <= S_ABORT;
                        end else begin
                            r_rdata <= LT_RDATA;
                            r_doe   <= 1'b1;
                            r_state <= S_R_DATA;
                        end
                    end else if (w_tmo_tc) begin
                        r_req   <= 1'b0;
                        r_trdy  <= 1'b1;
                        r_abort <= 1'b1;
                        r_state <= S_ABORT;
                    end else begin
                        r_tmo <= r_tmo + 4'd1;
                    end
                end
                S_R_DATA: begin
                    if (LBUS_IRDY) begin
                        r_trdy <= 1'b0;
                        r_doe  <= 1'b0;
                        if (LBUS_FRAME) begin
                            // burst continues: next word wraps inside the line
                            r_addr  <= w_addr_next;
                            r_req   <= 1'b1;
                            r_tmo   <= '0;
                            r_state <= S_R_FETCH;
                        end else begin
                            r_sel   <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_DONE, S_ABORT: begin
                    r_trdy  <= 1'b0;
                    r_abort <= 1'b0;
                    r_sel   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign LBUS_TRDY  = r_trdy;
    assign LBUS_SEL   = r_sel;
    assign LBUS_ABORT = r_abort;
    assign LBUS_RDATA = r_rdata;
    assign LBUS_DOE   = r_doe;
    assign LT_REQ     = r_req;
    assign LT_WE      = r_we;
    assign LT_ADDR    = r_addr;
    assign LT_WDATA   = r_wdata;

endmodule

// File: tb/tb_lbc_lbus_target.sv
// Bench for lbc_lbus_target: a directed transaction table, hand-written reset
// and miss sequences, then random transactions checked against a timing model.
module tb_lbc_lbus_target;

    logic        clk = 1'b0;
    logic        rst, frame, irdy, trdy_in, wr, ack, err;
    logic [29:0] addr;
    logic [31:0] wdata, lt_rdata;
    logic        o_trdy, o_sel, o_abort, o_doe, o_req, o_we;
    logic [31:0] o_rdata, o_wdata;
    logic [29:0] o_addr;

    always #5 clk = ~clk;

    lbc_lbus_target dut (
        .BUSCLK       (clk),
        .RESET_LR     (rst),
        .LBUS_FRAME   (frame),
        .LBUS_IRDY    (irdy),
        .LBUS_TRDY_IN (trdy_in),
        .LBUS_WR      (wr),
        .LBUS_ADDR    (addr),
        .LBUS_WDATA   (wdata),
        .LBUS_TRDY    (o_trdy),
        .LBUS_SEL     (o_sel),
        .LBUS_ABORT   (o_abort),
        .LBUS_RDATA   (o_rdata),
        .LBUS_DOE     (o_doe),
        .LT_REQ       (o_req),
        .LT_WE        (o_we),
        .LT_ADDR      (o_addr),
        .LT_WDATA     (o_wdata),
        .LT_ACK       (ack),
        .LT_ERR       (err),
        .LT_RDATA     (lt_rdata)
    );

    typedef struct {
        logic [29:0] addr;
        logic        wr;
        logic [31:0] wdata;
        int          n;
        int          dly;
        logic        err;
        int          stall;
        logic        exp_hit;
        logic        exp_abort;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic hit;
        logic abort;
        int   lat;
        int   span;
        int   tcnt;
        int   req;
        int   acks;
        int   nrd;
    } exp_t;

    int n_cmp = 0;
    int n_bad = 0;

    logic        ob_sel, ob_abort;
    int          ob_lat, ob_span, ob_tcnt, ob_req;
    logic [29:0] q_addr[$];
    logic        q_we[$];
    logic [31:0] q_wd[$];
    logic [31:0] q_ackd[$];
    logic [31:0] q_rd[$];

    vec_t tbl[13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic is_hit(input logic [29:0] a);
        return (a & 30'h3FFF0000) == 30'h0;
    endfunction

    // Timing model: counts in cycles after the address-phase edge.
    function automatic exp_t model(input vec_t v);
        exp_t e;
        bit   tmo;
        e     = '{default: 0};
        e.hit = is_hit(v.addr);
        if (!e.hit) return e;
        tmo = (v.dly >= 15);
        e.tcnt = 1;
        if (v.wr) begin
            e.abort = tmo || v.err;
            e.lat   = 2 + (tmo ? 15 : v.dly + 1);
            e.span  = e.lat;
            e.req   = tmo ? 15 : v.dly + 1;
            e.acks  = tmo ? 0 : 1;
        end else if (tmo) begin
            e.abort = 1'b1;
            e.lat   = 16;
            e.span  = 16;
            e.req   = 15;
        end else if (v.err) begin
            e.abort = 1'b1;
            e.lat   = v.dly + 2;
            e.span  = e.lat;
            e.req   = v.dly + 1;
            e.acks  = 1;
        end else begin
            e.lat  = v.dly + 2;
            e.span = v.n * (v.dly + 2) + v.stall;
            e.tcnt = v.n + v.stall;
            e.req  = v.n * (v.dly + 1);
            e.acks = v.n;
            e.nrd  = v.n;
        end
        return e;
    endfunction

    task automatic run_txn(input vec_t v);
        int   age, beats, stall_left;
        bit   done;
        logic [31:0] held;
        ob_sel = 0; ob_abort = 0; ob_lat = 0; ob_span = 0; ob_tcnt = 0; ob_req = 0;
        q_addr.delete(); q_we.delete(); q_wd.delete(); q_ackd.delete(); q_rd.delete();
        frame = 1; irdy = 1; wr = v.wr; addr = v.addr; wdata = $urandom;
        ack = 0; err = 0; trdy_in = 0;
        step();
        if (!is_hit(v.addr)) begin
            for (int k = 1; k <= 3; k++) begin
                if (o_sel) ob_sel = 1;
                chk("miss_quiet", 64'({o_sel, o_trdy, o_abort, o_doe, o_req}), 64'(0));
                case (k)
                    1: begin trdy_in = 1; frame = 1; irdy = 1; end
                    2: begin trdy_in = 0; frame = 1; irdy = 1; addr = 30'h20; wr = 1; end
                    default: begin trdy_in = 1; frame = 0; irdy = 1; end
                endcase
                step();
            end
            trdy_in = 0; frame = 0; irdy = 0;
            chk("miss_exit_sel", 64'(o_sel), 64'(0));
            return;
        end
        if (v.wr) begin frame = 0; wdata = v.wdata; end
        else frame = (v.n > 1);
        irdy = 1; age = 0; beats = 0; done = 0; stall_left = v.stall; held = '0;
        for (int k = 1; k <= 80 && !done; k++) begin
            if (o_sel) ob_sel = 1;
            if (o_req) begin
                ob_req++;
                if (age == v.dly) begin
                    ack = 1; err = v.err; lt_rdata = $urandom;
                    q_addr.push_back(o_addr); q_we.push_back(o_we); q_wd.push_back(o_wdata);
                    if (!v.err) q_ackd.push_back(lt_rdata);
                    age = 0;
                end else begin
                    ack = 0; err = 1'($urandom_range(0, 1)); age++;
                end
            end else begin
                ack = ($urandom_range(0, 3) == 0); err = 1'($urandom_range(0, 1));
                lt_rdata = $urandom; age = 0;
            end
            if (o_trdy) begin
                ob_tcnt++;
                if (ob_lat == 0) ob_lat = k;
                ob_span = k;
                if (o_abort) begin
                    ob_abort = 1;
                    chk("abort_doe", 64'(o_doe), 64'(0));
                    done = 1;
                end else if (v.wr) begin
                    done = 1;
                end else if (beats == 0 && stall_left > 0) begin
                    if (stall_left < v.stall) begin
                        chk("stall_rdata", 64'(o_rdata), 64'(held));
                        chk("stall_doe", 64'(o_doe), 64'(1));
                        chk("stall_noreq", 64'(o_req), 64'(0));
                    end else begin
                        held = o_rdata;
                    end
                    irdy = 0;
                    stall_left--;
                end else begin
                    irdy = 1;
                    frame = (beats != v.n - 1);
                    q_rd.push_back(o_rdata);
                    beats++;
                    if (beats == v.n) done = 1;
                end
            end else if (!v.wr) begin
                irdy = 1;
                frame = (beats != v.n - 1);
            end
            step();
        end
        if (!done) chk("txn_timeout", 64'(0), 64'(1));
        frame = 0; irdy = 0; ack = 0; err = 0;
        chk("end_idle", 64'({o_sel, o_trdy, o_abort, o_doe, o_req}), 64'(0));
    endtask

    task automatic check_txn(input vec_t v, input exp_t e, input bit use_tbl);
        logic [29:0] base, ea;
        chk("sel", 64'(ob_sel), 64'(use_tbl ? v.exp_hit : e.hit));
        if (!e.hit) return;
        chk("abort", 64'(ob_abort), 64'(use_tbl ? v.exp_abort : e.abort));
        chk("latency", 64'(ob_lat), 64'(use_tbl ? v.exp_lat : e.lat));
        chk("span", 64'(ob_span), 64'(e.span));
        chk("trdy_cycles", 64'(ob_tcnt), 64'(e.tcnt));
        chk("req_cycles", 64'(ob_req), 64'(e.req));
        chk("ack_count", 64'(q_addr.size()), 64'(e.acks));
        chk("beat_count", 64'(q_rd.size()), 64'(e.nrd));
        base = v.addr - (v.addr % 4);
        for (int i = 0; i < q_addr.size() && i < e.acks; i++) begin
            ea = base + 30'((v.addr % 4 + 30'(i)) % 4);
            chk("lt_addr", 64'(q_addr[i]), 64'(ea));
            chk("lt_we", 64'(q_we[i]), 64'(v.wr));
            if (v.wr) chk("lt_wdata", 64'(q_wd[i]), 64'(v.wdata));
        end
        for (int i = 0; i < q_rd.size() && i < q_ackd.size(); i++)
            chk("rdata", 64'(q_rd[i]), 64'(q_ackd[i]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        exp_t e;
        int   dsel[7] = '{0, 0, 1, 2, 3, 14, 15};

        //          addr        wr  wdata          n  dly err stall hit abort lat
        tbl[0]  = '{30'h10,     1, 32'hDEADBEEF, 1, 2,  0, 0, 1, 0, 5};
        tbl[1]  = '{30'h6,      0, 32'h0,        4, 0,  0, 0, 1, 0, 2};
        tbl[2]  = '{30'h6,      0, 32'h0,        2, 0,  0, 3, 1, 0, 2};
        tbl[3]  = '{30'h20,     1, 32'h12345678, 1, 15, 0, 0, 1, 1, 17};
        tbl[4]  = '{30'h20,     1, 32'h87654321, 1, 14, 0, 0, 1, 0, 17};
        tbl[5]  = '{30'h30,     1, 32'hCAFEF00D, 1, 0,  1, 0, 1, 1, 3};
        tbl[6]  = '{30'h8,      0, 32'h0,        2, 15, 0, 0, 1, 1, 16};
        tbl[7]  = '{30'h9,      0, 32'h0,        1, 14, 0, 0, 1, 0, 16};
        tbl[8]  = '{30'h5,      0, 32'h0,        3, 1,  1, 0, 1, 1, 3};
        tbl[9]  = '{30'h1000_0000, 1, 32'h0,     1, 0,  0, 0, 0, 0, 0};
        tbl[10] = '{30'h11,     1, 32'hA5A5A5A5, 1, 0,  0, 0, 1, 0, 3};
        tbl[11] = '{30'h12,     1, 32'h5A5A5A5A, 1, 0,  0, 0, 1, 0, 3};
        tbl[12] = '{30'h3FFF,   0, 32'h0,        3, 1,  0, 0, 1, 0, 3};

        rst = 1; frame = 0; irdy = 0; trdy_in = 0; wr = 0; addr = '0;
        wdata = '0; ack = 0; err = 0; lt_rdata = '0;
        step(); step();
        chk("reset_ctl", 64'({o_sel, o_trdy, o_abort, o_doe, o_req, o_we}), 64'(0));
        chk("reset_data", {o_rdata, o_wdata}, 64'(0));
        chk("reset_addr", 64'(o_addr), 64'(0));
        rst = 0;
        step();

        for (int t = 0; t < 13; t++) begin
            e = model(tbl[t]);
            run_txn(tbl[t]);
            check_txn(tbl[t], e, 1);
        end

        // reset while read data is on the bus
        frame = 1; irdy = 1; wr = 0; addr = 30'h40;
        step();
        frame = 1; irdy = 0; ack = 1; err = 0; lt_rdata = 32'h1357_9BDF;
        step();
        ack = 0;
        chk("rst_pre_trdy", 64'({o_trdy, o_doe, o_sel}), 64'(3'b111));
        chk("rst_pre_rdata", 64'(o_rdata), 64'(32'h1357_9BDF));
        rst = 1;
        step();
        chk("rst_mid_ctl", 64'({o_sel, o_trdy, o_abort, o_doe, o_req, o_we}), 64'(0));
        chk("rst_mid_data", {o_rdata, 2'b00, o_addr}, 64'(0));
        rst = 0; frame = 0; irdy = 0;
        step();
        e = model(tbl[0]);
        run_txn(tbl[0]);
        check_txn(tbl[0], e, 1);

        for (int r = 0; r < 40; r++) begin
            v.wr    = 1'($urandom_range(0, 1));
            v.n     = v.wr ? 1 : $urandom_range(1, 4);
            v.addr  = 30'($urandom) & 30'h0000FFFF;
            if ($urandom_range(0, 7) == 0) v.addr[29:16] = 14'($urandom_range(1, 16383));
            v.dly   = dsel[$urandom_range(0, 6)];
            v.err   = ($urandom_range(0, 7) == 0);
            v.stall = v.wr ? 0 : $urandom_range(0, 2);
            v.wdata = $urandom;
            v.exp_hit = 0; v.exp_abort = 0; v.exp_lat = 0;
            e = model(v);
            run_txn(v);
            check_txn(v, e, 0);
            if ($urandom_range(0, 1) == 1) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
